// File: rtl/mips_data_stall_bridge.sv
// rtl/mips_data_stall_bridge.sv - stalls a Harvard MIPS data port onto a held request/waitrequest memory bus
module mips_data_stall_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_enable,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        clock_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error,
  output logic [15:0] stall_count
);

  // Wait counter only has to reach TIMEOUT_CYCLES-1; a zero timeout disables the abort path.
  localparam int unsigned WCW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT_CYCLES > 0) ? WCW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e         state_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q;
  logic           mem_read_q;
  logic           mem_write_q;
  logic           bus_error_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [15:0]    stall_count_q;
  logic [15:0]    stall_count_d;

  logic cpu_req;
  logic stall_active;
  logic wait_expired;

  assign cpu_req      = cpu_read | cpu_write;
  // The CPU is frozen while a request is being latched and for every bus cycle of the access.
  assign stall_active = ((state_q == ST_IDLE) && cpu_req) || (state_q == ST_ACCESS);
  // Abort on the TIMEOUT_CYCLES-th consecutive waitrequest cycle of an access.
  assign wait_expired = TIMEOUT_EN && mem_waitrequest && (wait_cnt_q == WAIT_LAST);

  // Stall the CPU combinationally so it never advances past an unfinished access; reset passes ext_enable through.
  always_comb begin
    clock_enable = ext_enable;
    if (reset && stall_active) begin
      clock_enable = 1'b0;
    end
  end

  // Saturating stall counter next-state.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_active && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Access FSM with registered bus strobes, captured read data and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      bus_error_q   <= 1'b0;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q      <= {cpu_address[31:2], 2'b00};
            wdata_q     <= cpu_writedata;
            // A simultaneous read+write is a protocol violation: the write wins.
            mem_write_q <= cpu_write;
            mem_read_q  <= ~cpu_write;
            wait_cnt_q  <= '0;
            if (cpu_read && cpu_write) begin
              bus_error_q <= 1'b1;
            end
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!mem_waitrequest) begin
            if (mem_read_q) begin
              rdata_q <= mem_readdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= ST_DONE;
          end else if (wait_expired) begin
            // Hung access: abandon it, hand the CPU a recognisable error word.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rdata_q     <= ERROR_DATA;
            bus_error_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Hold the result until the CPU actually gets a clock edge to sample it.
          if (ext_enable) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_readdata  = rdata_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign bus_error     = bus_error_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_mips_data_stall_bridge.sv
// tb/tb_mips_data_stall_bridge.sv - randomized self-checking bench for mips_data_stall_bridge
module tb_mips_data_stall_bridge;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ext_enable = 1'b1;
  logic [31:0] cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        clock_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic        bus_error;
  logic [15:0] stall_count;

  mips_data_stall_bridge #(.TIMEOUT_CYCLES(T), .ERROR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .ext_enable(ext_enable),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .clock_enable(clock_enable), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .bus_error(bus_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: waitrequest high for the first cur_wait cycles of each access.
  logic [31:0] dmem [bit [31:0]];
  int cur_wait = 0;
  int acc_cyc  = 0;

  function automatic logic [31:0] dmem_rd(input logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return mem_init(a);
  endfunction

  always @(posedge clk) begin
    if (reset && mem_write && !mem_waitrequest) dmem[mem_address] = mem_writedata;
    #1;
    if (mem_read || mem_write) begin
      mem_waitrequest = (acc_cyc < cur_wait);
      mem_readdata    = (mem_read && !mem_waitrequest) ? dmem_rd(mem_address) : $urandom;
      acc_cyc++;
    end else begin
      acc_cyc         = 0;
      mem_waitrequest = 1'($urandom_range(0, 1));
      mem_readdata    = $urandom;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] exp_rdata = '0;
  logic        exp_berr  = 1'b0;
  int          exp_stall = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_init(a);
  endfunction

  // One CPU access; entered and left just after a rising edge with the bridge idle.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int nw, input int hold);
    logic [31:0] wa;
    logic [1:0]  kind_exp;
    bit          tmo;
    int          acc_exp, stalls, strobes, guard;
    wa       = {addr[31:2], 2'b00};
    tmo      = (nw >= T);
    acc_exp  = tmo ? T : nw + 1;
    kind_exp = wr ? 2'b01 : 2'b10;
    if (rd && wr) exp_berr = 1'b1;
    if (tmo) begin
      exp_berr  = 1'b1;
      exp_rdata = ERR;
    end else if (wr) begin
      ref_mem[wa] = wd;
    end else begin
      exp_rdata = ref_rd(wa);
    end
    exp_stall = (exp_stall + acc_exp + 1 > 65535) ? 65535 : exp_stall + acc_exp + 1;

    cur_wait = nw;
    cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wd;
    stalls = 0; strobes = 0; guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (guard > 40) begin
        check_eq("access_bound", guard, 40);
        cpu_read = 1'b0; cpu_write = 1'b0; ext_enable = 1'b1;
        return;
      end
      if (mem_read || mem_write) begin
        strobes++;
        if (!clock_enable) stalls++;
        check_eq("strobe_kind", {30'd0, mem_read, mem_write}, {30'd0, kind_exp});
        check_eq("mem_address", mem_address, wa);
        if (wr) check_eq("mem_writedata", mem_writedata, wd);
        if (strobes == 1) begin
          cpu_address   = $urandom;
          cpu_writedata = $urandom;
        end
        if (strobes == acc_exp && hold > 0) ext_enable = 1'b0;
      end else if (strobes == 0) begin
        if (!clock_enable) stalls++;
      end else begin
        break;
      end
    end
    check_eq("access_cycles", strobes, acc_exp);
    check_eq("stall_cycles", stalls, acc_exp + 1);
    for (int h = hold; h > 0; h--) begin
      check_eq("ce_done_held", {31'd0, clock_enable}, 32'd0);
      check_eq("rdata_done_held", cpu_readdata, exp_rdata);
      if (h == 1) begin
        ext_enable = 1'b1;
        #1;
      end else begin
        @(negedge clk);
      end
    end
    check_eq("ce_done", {31'd0, clock_enable}, 32'd1);
    check_eq("cpu_readdata", cpu_readdata, exp_rdata);
    check_eq("bus_error", {31'd0, bus_error}, {31'd0, exp_berr});
    check_eq("stall_count", {16'd0, stall_count}, exp_stall);
    @(posedge clk); #2;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ext_enable = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("ce_idle", {31'd0, clock_enable}, {31'd0, ext_enable});
      @(posedge clk); #2;
    end
    ext_enable = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit rd, wr;
    int r;
    logic [31:0] a;

    // Reset state, with a request present to show clock_enable follows ext_enable.
    reset = 1'b0; cpu_read = 1'b1; ext_enable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ce", {31'd0, clock_enable}, 32'd1);
    check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check_eq("rst_mem_address", mem_address, 32'd0);
    check_eq("rst_mem_writedata", mem_writedata, 32'd0);
    check_eq("rst_cpu_readdata", cpu_readdata, 32'd0);
    check_eq("rst_bus_error", {31'd0, bus_error}, 32'd0);
    check_eq("rst_stall_count", {16'd0, stall_count}, 32'd0);
    ext_enable = 1'b0; #1;
    check_eq("rst_ce_low", {31'd0, clock_enable}, 32'd0);
    ext_enable = 1'b1; cpu_read = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;

    // Directed cases.
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 0);
    do_access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_ABCD, 3, 0);
    do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 1);
    do_access(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 0);
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 2, 2);

    // Reset in the middle of a long access.
    cur_wait = 20;
    cpu_read = 1'b1; cpu_address = 32'h0000_0040;
    repeat (3) @(negedge clk);
    check_eq("midrst_pre_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b0; #1;
    check_eq("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("midrst_mem_write", {31'd0, mem_write}, 32'd0);
    check_eq("midrst_ce", {31'd0, clock_enable}, 32'd1);
    check_eq("midrst_bus_error", {31'd0, bus_error}, 32'd0);
    cpu_read = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_rdata = '0; exp_berr = 1'b0; exp_stall = 0;
    @(posedge clk); #2;
    check_eq("postrst_stall_count", {16'd0, stall_count}, 32'd0);
    check_eq("postrst_cpu_readdata", cpu_readdata, 32'd0);
    idle_cycles(2);

    // Timeouts and the boundary just below.
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 100, 0);
    do_access(1'b0, 1'b1, 32'h0000_0104, 32'h55AA_55AA, T, 1);
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, T - 1, 0);
    do_access(1'b0, 1'b1, 32'h0000_0108, 32'h0BAD_F00D, T - 1, 0);
    do_access(1'b1, 1'b0, 32'h0000_010A, 32'h0, 0, 0);

    // Randomized back-to-back traffic with ext_enable toggling.
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      a  = 32'h0000_0200 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      do_access(rd, wr, a, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
